// File: rtl/conv2d_window_scheduler_if.sv
// Bus bundle between the window scheduler, pixel memory, the dot-product engine and
// the result stream. Master = scheduler side, slave = memory/engine/downstream side.
interface conv2d_window_scheduler_if #(
    parameter int FILTER_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int DIM_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 16
);
    logic                                               mem_rd_en;
    logic [ADDR_WIDTH-1:0]                              mem_addr;
    logic [DATA_WIDTH-1:0]                              mem_rd_data;
    logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] image_patch;
    logic [2*DATA_WIDTH-1:0]                            conv_result;
    logic [2*DATA_WIDTH-1:0]                            out_data;
    logic [DIM_WIDTH-1:0]                               out_row;
    logic [DIM_WIDTH-1:0]                               out_col;
    logic                                               out_valid;
    logic                                               out_ready;

    modport master (
        output mem_rd_en, mem_addr, image_patch, out_data, out_row, out_col, out_valid,
        input  mem_rd_data, conv_result, out_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, image_patch, out_data, out_row, out_col, out_valid,
        output mem_rd_data, conv_result, out_ready
    );
endinterface

// File: rtl/conv2d_window_scheduler.sv
// Walks every valid FILTER_SIZE x FILTER_SIZE window of an image in pixel memory, gathers
// each window into a patch for the combinational engine and streams one result per window.
module conv2d_window_scheduler #(
    parameter int FILTER_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int DIM_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [DIM_WIDTH-1:0] i_img_width,
    input  logic [DIM_WIDTH-1:0] i_img_height,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    conv2d_window_scheduler_if.master bus
);

    localparam int PATCH_N = FILTER_SIZE * FILTER_SIZE;
    localparam int CNT_W   = $clog2(PATCH_N + 1);
    localparam int IDX_W   = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam logic [DIM_WIDTH-1:0] FS_DIM  = DIM_WIDTH'(FILTER_SIZE);
    localparam logic [IDX_W-1:0]     IDX_MAX = IDX_W'(FILTER_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_COMPUTE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [DIM_WIDTH-1:0]  r_w;
    logic [DIM_WIDTH-1:0]  r_h;
    logic [DIM_WIDTH-1:0]  r_row;
    logic [DIM_WIDTH-1:0]  r_col;
    logic [CNT_W-1:0]      r_k;
    logic [IDX_W-1:0]      r_fi;
    logic [IDX_W-1:0]      r_fj;
    logic                  r_cap_en;
    logic [IDX_W-1:0]      r_cap_i;
    logic [IDX_W-1:0]      r_cap_j;
    logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] r_patch;
    logic [2*DATA_WIDTH-1:0] r_out_data;
    logic [DIM_WIDTH-1:0]  r_out_row;
    logic [DIM_WIDTH-1:0]  r_out_col;
    logic                  r_out_valid;
    logic                  r_err;

    logic                  w_dims_ok;
    logic                  w_fetch_last;
    logic                  w_rd_en;
    logic                  w_last_col;
    logic                  w_last_row;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_dims_ok    = (i_img_width >= FS_DIM) && (i_img_height >= FS_DIM);
    assign w_fetch_last = (r_k == CNT_W'(PATCH_N));
    assign w_rd_en      = (r_state == S_FETCH) && !w_fetch_last;
    assign w_last_col   = (r_col == r_w - FS_DIM);
    assign w_last_row   = (r_row == r_h - FS_DIM);
    assign w_addr       = (ADDR_WIDTH'(r_row) + ADDR_WIDTH'(r_fi)) * ADDR_WIDTH'(r_w)
                        + ADDR_WIDTH'(r_col) + ADDR_WIDTH'(r_fj);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:    if (i_start && w_dims_ok) w_next_state = S_FETCH;
            S_FETCH:   if (w_fetch_last)         w_next_state = S_COMPUTE;
            S_COMPUTE:                           w_next_state = S_OUTPUT;
            S_OUTPUT:  if (bus.out_ready)
                           w_next_state = (w_last_row && w_last_col) ? S_DONE : S_FETCH;
            S_DONE:                              w_next_state = S_IDLE;
            default:                             w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy          = (r_state != S_IDLE);
        o_done          = (r_state == S_DONE);
        o_err           = r_err;
        bus.mem_rd_en   = w_rd_en;
        bus.mem_addr    = w_rd_en ? w_addr : '0;
        bus.image_patch = r_patch;
        bus.out_data    = r_out_data;
        bus.out_row     = r_out_row;
        bus.out_col     = r_out_col;
        bus.out_valid   = r_out_valid;
    end

    // NOTE: the patch array is reset explicitly; it is small and the engine must see zeros after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w         <= '0;
            r_h         <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_k         <= '0;
            r_fi        <= '0;
            r_fj        <= '0;
            r_cap_en    <= 1'b0;
            r_cap_i     <= '0;
            r_cap_j     <= '0;
            r_patch     <= '0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err    <= (r_state == S_IDLE) && i_start && !w_dims_ok;
            // Read data returns one cycle after the strobe, so the patch slot index is delayed too.
            r_cap_en <= w_rd_en;
            r_cap_i  <= r_fi;
            r_cap_j  <= r_fj;
            if (r_cap_en) r_patch[r_cap_i][r_cap_j] <= bus.mem_rd_data;

            unique case (r_state)
                S_IDLE: begin
                    if (i_start && w_dims_ok) begin
                        r_w   <= i_img_width;
                        r_h   <= i_img_height;
                        r_row <= '0;
                        r_col <= '0;
                        r_k   <= '0;
                        r_fi  <= '0;
                        r_fj  <= '0;
                    end
                end
                S_FETCH: begin
                    if (!w_fetch_last) begin
                        r_k <= r_k + CNT_W'(1);
                        if (r_fj == IDX_MAX) begin
                            r_fj <= '0;
                            r_fi <= r_fi + IDX_W'(1);
                        end else begin
                            r_fj <= r_fj + IDX_W'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    r_out_data  <= bus.conv_result;
                    r_out_row   <= r_row;
                    r_out_col   <= r_col;
                    r_out_valid <= 1'b1;
                end
                S_OUTPUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_k         <= '0;
                        r_fi        <= '0;
                        r_fj        <= '0;
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + DIM_WIDTH'(1);
                        end else begin
                            r_col <= r_col + DIM_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_window_scheduler.sv
// Self-checking bench for conv2d_window_scheduler: pixel memory and engine models,
// start-acceptance table, fixed images with known sums, stalls, reset abort and random images.
module tb_conv2d_window_scheduler;

    localparam int FS   = 3;
    localparam int DW   = 8;
    localparam int DIMW = 8;
    localparam int AW   = 16;

    typedef struct packed {
        logic [2*DW-1:0] data;
        logic [DIMW-1:0] row;
        logic [DIMW-1:0] col;
    } res_t;

    typedef struct {
        int w;
        int h;
        bit exp_err;
        bit exp_busy;
    } start_vec_t;

    logic            clk;
    logic            rst;
    logic            start;
    logic [DIMW-1:0] img_w;
    logic [DIMW-1:0] img_h;
    logic            busy;
    logic            done;
    logic            err;

    conv2d_window_scheduler_if #(.FILTER_SIZE(FS), .DATA_WIDTH(DW), .DIM_WIDTH(DIMW), .ADDR_WIDTH(AW)) bus ();

    conv2d_window_scheduler #(.FILTER_SIZE(FS), .DATA_WIDTH(DW), .DIM_WIDTH(DIMW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_img_width  (img_w),
        .i_img_height (img_h),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .bus          (bus)
    );

    logic [DW-1:0] pix [256];
    logic [DW-1:0] wt  [FS][FS];
    res_t          exp_q[$];
    int            addr_exp[$];
    int            addr_log[$];
    int            vec_cnt;
    int            miss_cnt;
    int            ready_mode;
    int            pass_id;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port pixel memory with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= pix[bus.mem_addr[7:0]];
    end

    // Combinational dot-product engine.
    always_comb begin
        logic [2*DW-1:0] acc;
        acc = '0;
        for (int i = 0; i < FS; i++)
            for (int j = 0; j < FS; j++)
                acc = acc + (2*DW)'(bus.image_patch[i][j]) * (2*DW)'(wt[i][j]);
        bus.conv_result = acc;
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = refuse the first result for 5 cycles.
    initial begin
        int seen_pass;
        int hold_left;
        seen_pass     = 0;
        hold_left     = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pass_id != seen_pass) begin
                seen_pass = pass_id;
                hold_left = 5;
            end
            case (ready_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (hold_left == 0) begin
                        bus.out_ready = 1'b1;
                    end else begin
                        bus.out_ready = 1'b0;
                        if (bus.out_valid) hold_left--;
                    end
                end
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: every window in row-major order, addresses and weighted sums from plain arithmetic.
    task automatic model_fill(input int w, input int h);
        logic [2*DW-1:0] acc;
        exp_q.delete();
        addr_exp.delete();
        for (int r = 0; r <= h - FS; r++)
            for (int c = 0; c <= w - FS; c++) begin
                acc = '0;
                for (int i = 0; i < FS; i++)
                    for (int j = 0; j < FS; j++) begin
                        addr_exp.push_back((r + i) * w + c + j);
                        acc = acc + (2*DW)'(pix[(r + i) * w + c + j]) * (2*DW)'(wt[i][j]);
                    end
                exp_q.push_back({acc, DIMW'(r), DIMW'(c)});
            end
    endtask

    task automatic load_ramp(input int n);
        for (int a = 0; a < 256; a++) pix[a] = (a < n) ? DW'(a + 1) : '0;
    endtask

    task automatic set_weights_ones();
        for (int i = 0; i < FS; i++)
            for (int j = 0; j < FS; j++) wt[i][j] = 8'd1;
    endtask

    task automatic run_pass(input int w, input int h, input int mode, input bit chk_period,
                            input bit inject, input string tag);
        bit   got_done;
        bit   prev_valid;
        bit   prev_stall;
        int   err_cnt;
        int   stall_cnt;
        int   last_rise;
        int   mism;
        int   nwin;
        int   addr_cyc[$];
        logic [31:0] prev_obs;
        logic [31:0] obs;
        res_t e;

        ready_mode = mode;
        pass_id++;
        addr_log.delete();
        got_done   = 1'b0;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        err_cnt    = 0;
        stall_cnt  = 0;
        last_rise  = -1;
        prev_obs   = '0;

        @(negedge clk);
        start = 1'b1;
        img_w = DIMW'(w);
        img_h = DIMW'(h);
        for (int n = 0; n < 4000 && !got_done; n++) begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
            obs = {bus.out_data, bus.out_row, bus.out_col};
            if (bus.mem_rd_en) begin
                addr_log.push_back(int'(bus.mem_addr));
                addr_cyc.push_back(n);
            end
            if (err)  err_cnt++;
            if (done) got_done = 1'b1;
            if (prev_stall) begin
                stall_cnt++;
                check({tag, "/stall_hold"}, {bus.out_valid, obs, bus.mem_rd_en}, {1'b1, prev_obs, 1'b0});
            end
            if (bus.out_valid && !prev_valid) begin
                if (chk_period && last_rise >= 0) check({tag, "/window_period"}, n - last_rise, 12);
                last_rise = n;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "/extra_result"}, obs, 0);
                    vec_cnt--;
                    if (obs === 0) begin miss_cnt++; $display("FAIL %s/extra_result: got result, expected none", tag); end
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "/result"}, obs, e);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_valid = bus.out_valid;
            prev_obs   = obs;
            if (inject) begin
                if (n == 20) begin start = 1'b1; img_w = 8'd7; img_h = 8'd3; end
                if (n == 21) start = 1'b0;
                if (n == 30) begin start = 1'b1; img_w = 8'd2; img_h = 8'd5; end
                if (n == 31) start = 1'b0;
            end
        end
        check({tag, "/done_seen"}, got_done, 1);
        @(negedge clk);
        check({tag, "/idle_after_done"}, {busy, done, bus.mem_rd_en, bus.out_valid}, 0);
        check({tag, "/results_left"}, exp_q.size(), 0);
        check({tag, "/err_quiet"}, err_cnt, 0);
        check({tag, "/addr_count"}, addr_log.size(), addr_exp.size());
        mism = 0;
        for (int k = 0; k < addr_log.size() && k < addr_exp.size(); k++)
            if (addr_log[k] != addr_exp[k]) mism++;
        check({tag, "/addr_seq"}, mism, 0);
        mism = 0;
        nwin = addr_cyc.size() / (FS * FS);
        for (int wd = 0; wd < nwin; wd++)
            for (int m = 1; m < FS * FS; m++)
                if (addr_cyc[wd*FS*FS + m] != addr_cyc[wd*FS*FS] + m) mism++;
        check({tag, "/addr_consecutive"}, mism, 0);
        if (mode == 2) check({tag, "/stall_cycles"}, stall_cnt, 5);
        start = 1'b0;
    endtask

    initial begin
        start_vec_t sv[$];
        int         exp_a[9];
        int         mism;
        bit         found;
        int         rw;
        int         rh;

        vec_cnt    = 0;
        miss_cnt   = 0;
        ready_mode = 0;
        pass_id    = 0;
        rst        = 1'b1;
        start      = 1'b0;
        img_w      = '0;
        img_h      = '0;
        set_weights_ones();
        load_ramp(0);

        sv.push_back('{3,   3,   1'b0, 1'b1});
        sv.push_back('{2,   5,   1'b1, 1'b0});
        sv.push_back('{5,   2,   1'b1, 1'b0});
        sv.push_back('{0,   0,   1'b1, 1'b0});
        sv.push_back('{2,   2,   1'b1, 1'b0});
        sv.push_back('{3,   255, 1'b0, 1'b1});
        sv.push_back('{8,   3,   1'b0, 1'b1});

        // Reset state.
        @(negedge clk);
        check("rst_outputs", {busy, done, err, bus.mem_rd_en, bus.mem_addr, bus.out_valid,
                              bus.out_data, bus.out_row, bus.out_col}, 0);
        check("rst_patch", |bus.image_patch, 0);
        @(negedge clk);
        rst = 1'b0;

        // Start acceptance table.
        foreach (sv[k]) begin
            @(negedge clk);
            start = 1'b1;
            img_w = DIMW'(sv[k].w);
            img_h = DIMW'(sv[k].h);
            @(negedge clk);
            start = 1'b0;
            check($sformatf("start%0d_err", k),   err,           sv[k].exp_err);
            check($sformatf("start%0d_busy", k),  busy,          sv[k].exp_busy);
            check($sformatf("start%0d_rd_en", k), bus.mem_rd_en, sv[k].exp_busy);
            @(negedge clk);
            check($sformatf("start%0d_err_end", k),   err,  0);
            check($sformatf("start%0d_busy_hold", k), busy, sv[k].exp_busy);
            if (sv[k].exp_busy) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        // 3x3 image: a single window summing 1..9.
        load_ramp(9);
        model_fill(3, 3);
        exp_q.delete();
        exp_q.push_back({16'd45, 8'd0, 8'd0});
        run_pass(3, 3, 0, 1'b1, 1'b0, "img3x3");

        // 4x4 image with known sums; start pulses during the pass must be ignored.
        load_ramp(16);
        model_fill(4, 4);
        exp_q.delete();
        exp_q.push_back({16'd54, 8'd0, 8'd0});
        exp_q.push_back({16'd63, 8'd0, 8'd1});
        exp_q.push_back({16'd90, 8'd1, 8'd0});
        exp_q.push_back({16'd99, 8'd1, 8'd1});
        run_pass(4, 4, 0, 1'b1, 1'b1, "img4x4");

        // 5 wide x 4 high: window (1,2) reads a fixed address run.
        load_ramp(20);
        model_fill(5, 4);
        run_pass(5, 4, 0, 1'b1, 1'b0, "img5x4");
        exp_a = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
        mism = 0;
        for (int k = 0; k < 9; k++)
            if (addr_log.size() <= 45 + k || addr_log[45 + k] != exp_a[k]) mism++;
        check("img5x4/window_1_2_addrs", mism, 0);

        // First result refused for 5 cycles.
        load_ramp(16);
        model_fill(4, 4);
        run_pass(4, 4, 2, 1'b0, 1'b0, "stall4x4");

        // Reset while fetching the second window.
        load_ramp(16);
        ready_mode = 0;
        pass_id++;
        @(negedge clk);
        start = 1'b1;
        img_w = 8'd4;
        img_h = 8'd4;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (bus.out_valid) found = 1'b1;
        end
        check("abort/first_result_seen", found, 1);
        repeat (4) @(posedge clk);
        #1;
        check("abort/fetching_window2", {bus.mem_rd_en, busy}, 2'b11);
        #1;
        rst = 1'b1;
        #1;
        check("abort/outputs_zero", {busy, done, err, bus.mem_rd_en, bus.mem_addr, bus.out_valid,
                                     bus.out_data, bus.out_row, bus.out_col}, 0);
        check("abort/patch_zero", |bus.image_patch, 0);
        @(negedge clk);
        rst = 1'b0;
        model_fill(4, 4);
        run_pass(4, 4, 1, 1'b0, 1'b0, "after_abort");

        // Random images and weights against the reference model.
        for (int t = 0; t < 6; t++) begin
            rw = $urandom_range(3, 10);
            rh = $urandom_range(3, 8);
            for (int a = 0; a < 256; a++) pix[a] = DW'($urandom);
            for (int i = 0; i < FS; i++)
                for (int j = 0; j < FS; j++) wt[i][j] = DW'($urandom);
            model_fill(rw, rh);
            run_pass(rw, rh, 1, 1'b0, 1'b0, $sformatf("rand%0d_%0dx%0d", t, rw, rh));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
